sop_tracker: RTL



---
 rtl/sop_pkg.sv | 13 +
 rtl/sop_err_counter.sv | 22 ++
 rtl/sop_tracker.sv | 113 +++++++++++
 3 files changed

// File: rtl/sop_pkg.sv
// Shared types and defaults for the SOP receive tracker.
package sop_pkg;

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED,
      FLYWHEEL
   } sop_state_t;

   localparam int SOP_PERIOD_DEFAULT = 256;

endpackage

// File: rtl/sop_err_counter.sv
// Saturating error counter; a clear wins over the old value but still counts a same-cycle error.
module sop_err_counter #(
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [ERR_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= {{(ERR_W-1){1'b0}}, inc};
      end else if (inc && (cnt != {ERR_W{1'b1}})) begin
         cnt <= cnt + ERR_W'(1);
      end
   end

endmodule

// File: rtl/sop_tracker.sv
// Qualifies the periodic SOP strobe, locks a phase counter to it and flywheels through isolated misses.
module sop_tracker
   import sop_pkg::*;
#(
   parameter int PERIOD   = SOP_PERIOD_DEFAULT,
   parameter int CNT_W    = $clog2(PERIOD),
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 2,
   parameter int ERR_W    = 16
) (
   input  logic             clk_line,
   input  logic             rst_n,
   input  logic             plain_in_start_of_processing,
   input  logic             err_cnt_clr,
   output logic             locked,
   output logic [CNT_W-1:0] phase_out,
   output logic             sop_aligned,
   output logic             sop_error,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(LOSS_CNT + 1);
   localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(PERIOD - 1);

   sop_state_t        state;
   logic [CNT_W-1:0]  ph;
   logic [CNT_W-1:0]  ph_next;
   logic [GOOD_W-1:0] good;
   logic [MISS_W-1:0] miss;
   logic              sop_in;
   logic              on_time;
   logic              err_event;

   assign sop_in  = plain_in_start_of_processing;
   assign on_time = (ph == '0);
   assign ph_next = (ph == PH_LAST) ? '0 : ph + CNT_W'(1);

   // Outside HUNT, any disagreement between the strobe and the expected slot is an error.
   assign err_event = (state != HUNT) && (sop_in ^ on_time);

   always_ff @(posedge clk_line or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         ph        <= '0;
         good      <= '0;
         miss      <= '0;
         sop_error <= 1'b0;
      end else begin
         sop_error <= err_event;
         ph        <= ph_next;
         case (state)
            HUNT: begin
               if (sop_in) begin
                  ph    <= CNT_W'(1);
                  good  <= GOOD_W'(1);
                  miss  <= '0;
                  state <= (LOCK_CNT == 1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               if (sop_in && on_time) begin
                  good <= good + GOOD_W'(1);
                  if (good == GOOD_W'(LOCK_CNT - 1)) begin
                     miss  <= '0;
                     state <= LOCKED;
                  end
               end else if (sop_in) begin
                  ph   <= CNT_W'(1);
                  good <= GOOD_W'(1);
               end else if (on_time) begin
                  good  <= '0;
                  state <= HUNT;
               end
            end
            LOCKED: begin
               // Spurious pulses are flagged but never re-align a locked phase.
               if (on_time && !sop_in) begin
                  miss  <= MISS_W'(1);
                  state <= (LOSS_CNT == 1) ? HUNT : FLYWHEEL;
               end
            end
            FLYWHEEL: begin
               if (on_time && sop_in) begin
                  miss  <= '0;
                  state <= LOCKED;
               end else if (on_time) begin
                  miss <= miss + MISS_W'(1);
                  if (miss == MISS_W'(LOSS_CNT - 1)) begin
                     state <= HUNT;
                  end
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   assign locked      = (state == LOCKED) || (state == FLYWHEEL);
   assign phase_out   = locked ? ph : '0;
   assign sop_aligned = locked && on_time;

   sop_err_counter #(
      .ERR_W(ERR_W)
   ) u_err_counter (
      .clk  (clk_line),
      .rst_n(rst_n),
      .clr  (err_cnt_clr),
      .inc  (err_event),
      .cnt  (err_cnt)
   );

endmodule
